// File: rtl/gcd_unit.sv
// GCD engine: subtractive Euclid or binary Stein, selected per request, with a start/done handshake.
// Latency: iters+1 clock edges from the accept edge to done rising.
// Backpressure: none; a start edge during CALC is ignored, and start must return low between requests.
module gcd_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             busy,
    output logic [CNT_W-1:0] iters,
    output logic             zero_flag
);
    localparam int K_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [K_W-1:0]   K_ONE   = K_W'(1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t           state_q, state_d;
    logic             start_q;
    logic             mode_q, mode_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [K_W-1:0]   k_q, k_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic [CNT_W-1:0] iters_q, iters_d;
    logic             done_q, done_d;
    logic             accept;

    assign accept = (state_q != S_CALC) && start && !start_q;

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        a_d      = a_q;
        b_d      = b_q;
        k_d      = k_q;
        result_d = result_q;
        zero_d   = zero_q;
        iters_d  = iters_q;
        done_d   = done_q;
        if (accept) begin
            a_d     = opa;
            b_d     = opb;
            mode_d  = mode;
            k_d     = '0;
            iters_d = '0;
            done_d  = 1'b0;
            state_d = S_CALC;
        end else if (state_q == S_CALC) begin
            if (a_q == '0 || b_q == '0) begin
                result_d = a_q | b_q;
                zero_d   = (a_q == '0) && (b_q == '0);
                done_d   = 1'b1;
                state_d  = S_DONE;
            end else if (a_q == b_q) begin
                result_d = mode_q ? (a_q << k_q) : a_q;
                zero_d   = 1'b0;
                done_d   = 1'b1;
                state_d  = S_DONE;
            end else begin
                if (iters_q != '1) iters_d = iters_q + CNT_ONE;
                // Euclid always subtracts; Stein subtracts only once both are odd.
                if (!mode_q || (a_q[0] && b_q[0])) begin
                    if (a_q > b_q) a_d = a_q - b_q;
                    else           b_d = b_q - a_q;
                end else if (!a_q[0] && !b_q[0]) begin
                    a_d = a_q >> 1;
                    b_d = b_q >> 1;
                    k_d = k_q + K_ONE;
                end else if (!a_q[0]) begin
                    a_d = a_q >> 1;
                end else begin
                    b_d = b_q >> 1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            start_q  <= 1'b0;
            mode_q   <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            k_q      <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            iters_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            start_q  <= start;
            mode_q   <= mode_d;
            a_q      <= a_d;
            b_q      <= b_d;
            k_q      <= k_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            iters_q  <= iters_d;
            done_q   <= done_d;
        end
    end

    assign result    = result_q;
    assign done      = done_q;
    assign busy      = (state_q == S_CALC);
    assign iters     = iters_q;
    assign zero_flag = zero_q;
endmodule

// File: tb/tb_gcd_unit.sv
// Bench for gcd_unit: directed and randomized requests scored against an arithmetic GCD/step-count model.
module tb_gcd_unit;
    logic        clk = 1'b0;
    logic        resetn, start, mode;
    logic [31:0] opa, opb, result, iters;
    logic        done, busy, zero_flag;
    logic        start8, mode8;
    logic [7:0]  opa8, opb8, result8, iters8;
    logic        done8, busy8, zero8;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    gcd_unit #(.WIDTH(32), .CNT_W(32)) dut (
        .clk(clk), .resetn(resetn), .start(start), .mode(mode), .opa(opa), .opb(opb),
        .result(result), .done(done), .busy(busy), .iters(iters), .zero_flag(zero_flag)
    );

    gcd_unit #(.WIDTH(8), .CNT_W(8)) dut8 (
        .clk(clk), .resetn(resetn), .start(start8), .mode(mode8), .opa(opa8), .opb(opb8),
        .result(result8), .done(done8), .busy(busy8), .iters(iters8), .zero_flag(zero8)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int tz(input logic [31:0] v);
        int n = 0;
        while (v[0] == 1'b0 && n < 32) begin
            v = v >> 1;
            n++;
        end
        return n;
    endfunction

    function automatic logic [31:0] ref_gcd(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // Subtractive steps equal the sum of division quotients, less one for the final equal pair.
    function automatic longint euclid_steps(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] x, y, r;
        longint s = 0;
        if (a == 0 || b == 0) return 0;
        x = (a > b) ? a : b;
        y = (a > b) ? b : a;
        forever begin
            r = x % y;
            if (r == 0) begin
                s += longint'(x / y) - 1;
                return s;
            end
            s += longint'(x / y);
            x = y;
            y = r;
        end
    endfunction

    // Halvings count once per shifted bit; each subtraction is followed by halving out its zeros.
    function automatic longint stein_steps(input logic [31:0] a, input logic [31:0] b);
        int ta, tb, k, t;
        longint s;
        if (a == 0 || b == 0 || a == b) return 0;
        ta = tz(a);
        tb = tz(b);
        k  = (ta < tb) ? ta : tb;
        s  = longint'(ta + tb - k);
        a  = a >> ta;
        b  = b >> tb;
        while (a != b) begin
            if (a > b) begin
                a = a - b; t = tz(a); a = a >> t;
            end else begin
                b = b - a; t = tz(b); b = b >> t;
            end
            s += longint'(1 + t);
        end
        return s;
    endfunction

    // style 0: drop start after accept; 1: hold start high; 2: toggle start and scramble inputs during CALC.
    task automatic do_op(input logic m, input logic [31:0] a, input logic [31:0] b, input int style,
                         input bit now, output logic [31:0] res, output logic [31:0] it);
        logic [31:0] eg;
        longint ei;
        int lat;
        bit seen, busy_ok;
        eg = ref_gcd(a, b);
        ei = m ? stein_steps(a, b) : euclid_steps(a, b);
        if (!now) @(negedge clk);
        mode = m; opa = a; opb = b; start = 1'b1;
        @(negedge clk);
        chk("done_low_after_accept", done, 0);
        chk("busy_after_accept", busy, 1);
        if (style == 0) start = 1'b0;
        seen = 0; busy_ok = 1; lat = 0;
        for (int n = 1; n <= ei + 10 && !seen; n++) begin
            if (style == 2) begin
                start = 1'($urandom_range(0, 1));
                mode  = 1'($urandom_range(0, 1));
                opa   = $urandom;
                opb   = $urandom;
            end
            @(negedge clk);
            if (done) begin
                seen = 1;
                lat  = n;
            end else if (!busy) begin
                busy_ok = 0;
            end
        end
        if (style != 1) start = 1'b0;
        chk("timeout", seen, 1);
        chk("busy_throughout", busy_ok, 1);
        chk("busy_low_in_done", busy, 0);
        chk("latency", lat, ei + 1);
        chk("result", result, eg);
        chk("iters", iters, ei);
        chk("zero_flag", zero_flag, (a == 0 && b == 0));
        res = result;
        it  = iters;
    endtask

    task automatic op8(input logic m, input logic [7:0] a, input logic [7:0] b);
        bit seen = 0;
        @(negedge clk);
        mode8 = m; opa8 = a; opb8 = b; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        for (int n = 0; n < 400 && !seen; n++) begin
            @(negedge clk);
            if (done8) seen = 1;
        end
        chk("w8_timeout", seen, 1);
        chk("w8_result", result8, ref_gcd(32'(a), 32'(b)));
        chk("w8_iters", iters8, m ? stein_steps(32'(a), 32'(b)) : euclid_steps(32'(a), 32'(b)));
    endtask

    initial begin
        logic [31:0] r, it, a, b, c;
        int sel, style, prev_style;
        resetn = 1'b1; start = 1'b0; mode = 1'b0; opa = '0; opb = '0;
        start8 = 1'b0; mode8 = 1'b0; opa8 = '0; opb8 = '0;
        #2 resetn = 1'b0;
        #2;
        chk("rst_result", result, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_iters", iters, 0);
        chk("rst_zero", zero_flag, 0);
        chk("rst_done8", done8, 0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;

        do_op(1'b0, 32'd102, 32'd12, 0, 0, r, it);
        chk("euclid_102_12_res", r, 6);
        chk("euclid_102_12_iters", it, 9);
        do_op(1'b1, 32'd102, 32'd12, 0, 0, r, it);
        chk("stein_102_12_res", r, 6);
        chk("stein_102_12_iters", it, 7);
        do_op(1'b0, 32'd23040, 32'd1944, 0, 0, r, it);
        chk("euclid_23040_res", r, 72);
        do_op(1'b1, 32'd23040, 32'd1944, 0, 0, r, it);
        chk("stein_23040_res", r, 72);
        do_op(1'b0, 32'd0, 32'd36915, 0, 0, r, it);
        chk("zero_a_res", r, 36915);
        chk("zero_a_iters", it, 0);
        chk("zero_a_flag", zero_flag, 0);
        do_op(1'b1, 32'd0, 32'd0, 0, 0, r, it);
        chk("zero_both_flag", zero_flag, 1);
        do_op(1'b1, 32'd23040, 32'd23040, 0, 0, r, it);
        chk("equal_res", r, 23040);
        chk("equal_iters", it, 0);

        // start held high past completion must not restart
        do_op(1'b0, 32'd1071, 32'd462, 1, 0, r, it);
        repeat (5) @(negedge clk);
        chk("hold_done", done, 1);
        chk("hold_busy", busy, 0);
        chk("hold_result", result, 21);
        start = 1'b0;
        @(negedge clk);
        do_op(1'b1, 32'd1071, 32'd462, 2, 0, r, it);
        @(negedge clk);
        // back-to-back: accept in the first DONE cycle
        do_op(1'b1, 32'd4096, 32'd640, 0, 0, r, it);
        do_op(1'b0, 32'd91, 32'd35, 0, 1, r, it);
        chk("b2b_res", r, 7);

        // reset in mid-calculation
        @(negedge clk);
        mode = 1'b0; opa = 32'd82066; opb = 32'd36915; start = 1'b1;
        @(posedge clk);
        repeat (3) @(posedge clk);
        #1 resetn = 1'b0;
        start = 1'b0;
        #1;
        chk("abort_result", result, 0);
        chk("abort_done", done, 0);
        chk("abort_busy", busy, 0);
        chk("abort_iters", iters, 0);
        chk("abort_zero", zero_flag, 0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        do_op(1'b0, 32'd82066, 32'd36915, 0, 0, r, it);
        chk("after_reset_res", r, 1);

        prev_style = 0;
        for (int i = 0; i < 60; i++) begin
            sel = $urandom_range(0, 7);
            if (i % 2 == 0) begin
                a = $urandom; b = $urandom;
                if (sel == 0) a = 0;
                if (sel == 1) b = a;
                if (sel == 2) begin a = a & 32'hFFFF_0000; b = b & 32'hFFFF_FF00; end
            end else begin
                c = $urandom_range(1, 1000);
                a = $urandom_range(0, 500) * c;
                b = $urandom_range(0, 500) * c;
                if (sel == 1) b = a;
            end
            style = (sel == 7) ? 2 : 0;
            do_op(1'(i % 2 == 0), a, b, style, (prev_style == 0) && ($urandom_range(0, 1) == 1), r, it);
            prev_style = style;
        end

        op8(1'b0, 8'd255, 8'd1);
        chk("w8_euclid_res", result8, 1);
        chk("w8_euclid_iters", iters8, 254);
        op8(1'b1, 8'd255, 8'd1);
        chk("w8_stein_res", result8, 1);
        op8(1'b1, 8'd192, 8'd48);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
